// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : shared encodings for the multiply/divide unit and hazard control
// Revision: 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/md_div_step.sv
// ============================================================================
// md_div_step : one combinational restoring-division step on magnitudes
// Revision: 1.0
// ============================================================================
`default_nettype none

module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // The remainder stays below the divisor, so the shifted value fits in WIDTH+1
  // bits and a negative trial result always shows up in the top bit.
  assign w_shift  = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, i_dvs};
  assign w_borrow = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl : iterative multiply/divide sequencer owning the HI/LO registers
// Optional single-cycle multiply when MDU_FAST_MULT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic             r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_div_zero;
  logic             w_fast;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_fix_prod;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_signed   = ~op[0];
  assign w_div_zero = op[1] && (b == '0);
  assign w_mag_a    = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b    = (w_signed && b[WIDTH-1]) ? -b : b;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_fast = ~op[1];
  assign w_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`else
  assign w_fast = 1'b0;
`endif

  // Multiply accumulator lives in {r_rem, r_quo}: the multiplier shifts out of
  // the low half while partial sums accumulate in the high half.
  assign w_mul_sum = {1'b0, r_rem} + {1'b0, (r_quo[0] ? r_dvs : {WIDTH{1'b0}})};

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  assign w_acc      = {r_rem, r_quo};
  assign w_fix_prod = (r_op == MD_MULT && (r_sa ^ r_sb)) ? -w_acc : w_acc;
  assign w_fix_quo  = (r_op == MD_DIV && (r_sa ^ r_sb)) ? -r_quo : r_quo;
  assign w_fix_rem  = (r_op == MD_DIV && r_sa) ? -r_rem : r_rem;

  always_comb begin
    w_fix_hi = w_fix_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_fix_prod[WIDTH-1:0];
    if (r_dz) begin
      w_fix_hi = r_rem;
      w_fix_lo = '1;
    end else if (r_op[1]) begin
      w_fix_hi = w_fix_rem;
      w_fix_lo = w_fix_quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (w_div_zero || w_fast) ? S_FIX : S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_sa  <= w_signed & a[WIDTH-1];
            r_sb  <= w_signed & b[WIDTH-1];
            r_dz  <= w_div_zero;
            r_cnt <= '0;
            if (w_div_zero) begin
              r_rem <= a;
              r_quo <= '0;
              r_dvs <= '0;
            end else if (op[1]) begin
              r_rem <= '0;
              r_quo <= w_mag_a;
              r_dvs <= w_mag_b;
            end else begin
`ifdef MDU_FAST_MULT_EN
              r_rem <= w_prod[2*WIDTH-1:WIDTH];
              r_quo <= w_prod[WIDTH-1:0];
`else
              r_rem <= '0;
              r_quo <= w_mag_b;
`endif
              r_dvs <= w_mag_a;
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[1]) begin
            r_rem <= w_div_rem;
            r_quo <= w_div_quo;
          end else begin
            {r_rem, r_quo} <= {w_mul_sum, r_quo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the multiply/divide unit in the EX stage of the pipelined MIPS CPU. Accepts mult/multu/div/divu from the EX-stage control with a one-cycle start pulse. Steps an iterative radix-2 shift-add/subtract datapath for WIDTH cycles and owns the architectural HI/LO registers. Exports `busy` so hazard control stalls dependent instructions in D.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  rs value (multiplicand / dividend)
- b  in  WIDTH  rt value (multiplier / divisor)
- mthi  in  1  write wdata to HI (IDLE only)
- mtlo  in  1  write wdata to LO (IDLE only)
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in the cycle after HI/LO take a result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start: latch |a| and |b| (magnitudes for signed ops, raw for unsigned), sign flags, and op. Clear the iteration counter and go to RUN.
- IDLE + start with div/divu and b == 0: go straight to FIX with no RUN cycles. FIX writes HI = a and LO = all ones.
- RUN, mult: one shift-add step per cycle into a 2·WIDTH accumulator.
- RUN, div: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- RUN: after WIDTH steps (counter == WIDTH-1), go to FIX.
- FIX, signed mult: negate the 2·WIDTH product if the operand signs differ.
- FIX, signed div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- FIX: write HI = product[2W-1:W] or remainder, and LO = product[W-1:0] or quotient. Return to IDLE.
- 0x80000000 / -1 (div): LO = 0x80000000, HI = 0. This falls out of magnitude negation with WIDTH-bit wrap.
- start while busy: ignored, with no effect on the operation in flight.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins; the mt write is dropped.
- mthi and mtlo together: both written.
- HI/LO change only on an mt write in IDLE or on the FIX edge.

## Timing
- Reset (async, any state): state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0. An operation in flight is abandoned.
- start sampled at edge k → busy high from after edge k through edge k+WIDTH+1.
- Results appear at hi/lo after edge k+WIDTH+1, and done is high for that one cycle. busy is already low in that cycle.
- For WIDTH=32: 33 busy cycles.
- Divide by zero: busy for 1 cycle, with the result after edge k+1.
- mthi/mtlo: hi/lo updated at the same edge, visible the next cycle.
- done never coincides with busy.
- A back-to-back start in the done cycle is accepted.

## Configuration
- MDU_FAST_MULT_EN defined:
  - mult/multu use a single combinational WIDTH×WIDTH multiply latched in IDLE.
  - They go IDLE→FIX directly, so busy lasts 1 cycle and the result lands after edge k+1.
  - Division is unchanged.
- MDU_FAST_MULT_EN undefined: mult/multu use the iterative RUN path, WIDTH+1 busy cycles.
- Architectural results are identical either way.

## Structure
- Shared package md_pkg holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encodings S_IDLE/S_RUN/S_FIX
  - the default WIDTH
- The pipeline hazard unit imports the op encodings from md_pkg.
- One sub-module: md_div_step, a combinational single restoring-division step.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once and reused every RUN cycle.

## Test plan
- Reset, then multu a=0xFFFFFFFF b=0xFFFFFFFF → busy for 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001, done pulses once.
- mult a=-3 (0xFFFFFFFD) b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. div a=-7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu a=100 b=0 → busy 1 cycle, HI=100, LO=0xFFFFFFFF. div a=0x80000000 b=-1 → LO=0x80000000, HI=0.
- Busy-phase rejection: while busy, pulse start (mult a=2 b=2) and mtlo wdata=0x55. The result equals the original op; LO never takes 0x55.
- In IDLE, mthi=1 and start=1 together → the op runs and HI is never written with wdata. mthi alone with wdata=0x1234 → hi=0x1234 the next cycle.
- Assert reset_n=0 mid-RUN (cycle 10) → busy, hi, lo and done drop to 0 immediately. A fresh start after release completes in the normal 33 cycles.
